// File: rtl/sid_write_sequencer.sv
// Timed SID register-write scheduler: FIFO of {delay, addr, data} entries, each issued
// as a one-clk sid_we after its delay in ce_1m ticks. Optional shadow regfile: SIDSEQ_SHADOW_EN.
module sid_write_sequencer #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DELAY_W    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce_1m,
    input  logic                  push_valid,
    output logic                  push_ready,
    input  logic [DELAY_W-1:0]    push_delay,
    input  logic [4:0]            push_addr,
    input  logic [7:0]            push_data,
    input  logic                  flush,
    output logic                  sid_we,
    output logic [4:0]            sid_addr,
    output logic [7:0]            sid_data,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  empty,
    output logic                  busy
`ifdef SIDSEQ_SHADOW_EN
    ,
    input  logic [4:0]            shadow_raddr,
    output logic [7:0]            shadow_rdata
`endif
);

    // state | meaning
    // IDLE  | no entry in flight; pops the FIFO head when one is available
    // WAIT  | counting down the popped entry's delay on ce_1m ticks
    // ISSUE | sid_we is high this cycle with the latched addr/data
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ISSUE = 2'd2
    } state_t;

    typedef struct packed {
        logic [DELAY_W-1:0] delay;
        logic [4:0]         addr;
        logic [7:0]         data;
    } entry_t;

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [DELAY_W-1:0]    CNT_ONE  = DELAY_W'(1);

    entry_t                  mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr;
    logic [DEPTH_LOG2-1:0]   rd_ptr;
    logic [DELAY_W-1:0]      cnt;
    logic [4:0]              lat_addr;
    logic [7:0]              lat_data;
    state_t                  state;
    state_t                  state_next;
    logic                    pop;
    logic                    push_fire;
    entry_t                  head;

    // Ready depends on the registered level only; a same-cycle pop never frees a slot early.
    assign push_ready = (level != LVL_FULL);
    assign push_fire  = push_valid & push_ready & ~flush;
    assign head       = mem[rd_ptr];
    assign busy       = (state != IDLE);
    assign empty      = (level == '0) && (state == IDLE);

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (level != '0) begin
                    pop        = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (ce_1m && (cnt == '0)) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (flush) begin
            state_next = IDLE;
            pop        = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem[wr_ptr] <= '{delay: push_delay, addr: push_addr, data: push_data};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            cnt      <= '0;
            lat_addr <= '0;
            lat_data <= '0;
            sid_we   <= 1'b0;
            sid_addr <= '0;
            sid_data <= '0;
        end else if (flush) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            cnt    <= '0;
            sid_we <= 1'b0;
        end else begin
            state <= state_next;
            if (push_fire) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + PTR_ONE;
                cnt      <= head.delay;
                lat_addr <= head.addr;
                lat_data <= head.data;
            end else if ((state == WAIT) && ce_1m && (cnt != '0)) begin
                cnt <= cnt - CNT_ONE;
            end
            case ({push_fire, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
            // Strobe is registered so it lands exactly one clk after the terminal ce_1m.
            sid_we <= (state_next == ISSUE);
            if (state_next == ISSUE) begin
                sid_addr <= lat_addr;
                sid_data <= lat_data;
            end
        end
    end

`ifdef SIDSEQ_SHADOW_EN
    logic [7:0] shadow [25];

    // Shadow tracks real SID registers only; flush leaves it intact.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 25; i++) begin
                shadow[i] <= '0;
            end
            shadow_rdata <= '0;
        end else begin
            if (sid_we && (sid_addr <= 5'd24)) begin
                shadow[sid_addr] <= sid_data;
            end
            shadow_rdata <= (shadow_raddr <= 5'd24) ? shadow[shadow_raddr] : 8'h00;
        end
    end
`endif

endmodule

// File: tb/tb_sid_write_sequencer.sv
// Directed self-checking bench for sid_write_sequencer; covers SIDSEQ_SHADOW_EN when defined.
module tb_sid_write_sequencer;

    logic        clk;
    logic        reset;
    logic        ce_1m;
    logic        push_valid;
    logic        push_ready;
    logic [15:0] push_delay;
    logic [4:0]  push_addr;
    logic [7:0]  push_data;
    logic        flush;
    logic        sid_we;
    logic [4:0]  sid_addr;
    logic [7:0]  sid_data;
    logic [4:0]  level;
    logic        empty;
    logic        busy;
`ifdef SIDSEQ_SHADOW_EN
    logic [4:0]  shadow_raddr;
    logic [7:0]  shadow_rdata;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int ce_count = 0;
    int last_ce_cyc = -10;
    int last_w_ce   = -1;
    int ce_period   = 32;
    bit ce_en       = 0;
    int ce0;

    logic [4:0] exp_a [$];
    logic [7:0] exp_d [$];
    logic [4:0] wq_a  [$];
    logic [7:0] wq_d  [$];
    int         wq_ce [$];

    sid_write_sequencer #(.DEPTH_LOG2(4), .DELAY_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .ce_1m      (ce_1m),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .push_delay (push_delay),
        .push_addr  (push_addr),
        .push_data  (push_data),
        .flush      (flush),
        .sid_we     (sid_we),
        .sid_addr   (sid_addr),
        .sid_data   (sid_data),
        .level      (level),
        .empty      (empty),
        .busy       (busy)
`ifdef SIDSEQ_SHADOW_EN
        ,
        .shadow_raddr (shadow_raddr),
        .shadow_rdata (shadow_rdata)
`endif
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ce_1m generator: driven on negedge, sampled by the DUT on the following posedge.
    initial begin
        int phase;
        phase = 0;
        ce_1m = 0;
        forever begin
            @(negedge clk);
            if (ce_en) begin
                if (phase >= ce_period - 1) begin
                    phase = 0;
                    ce_1m = 1;
                    ce_count++;
                    last_ce_cyc = cyc + 1;
                end else begin
                    phase++;
                    ce_1m = 0;
                end
            end else begin
                phase = 0;
                ce_1m = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Write monitor: strobe must fall in the clk right after a ce_1m, one write per tick.
    initial forever begin
        @(negedge clk);
        if (sid_we === 1'b1) begin
            wq_a.push_back(sid_addr);
            wq_d.push_back(sid_data);
            wq_ce.push_back(ce_count);
            check("we_after_tick", cyc, last_ce_cyc);
            check("one_write_per_tick", (ce_count != last_w_ce), 1);
            last_w_ce = ce_count;
        end
    end

    task automatic push(input logic [15:0] d, input logic [4:0] a, input logic [7:0] dt);
        push_valid = 1;
        push_delay = d;
        push_addr  = a;
        push_data  = dt;
        if (push_ready === 1'b1 && flush == 1'b0 && reset == 1'b0) begin
            exp_a.push_back(a);
            exp_d.push_back(dt);
        end
        @(negedge clk);
        push_valid = 0;
    endtask

    task automatic check_writes(input int budget);
        int n;
        for (int t = 0; t < budget && wq_a.size() < exp_a.size(); t++) @(negedge clk);
        check("write_count", wq_a.size(), exp_a.size());
        n = (wq_a.size() < exp_a.size()) ? wq_a.size() : exp_a.size();
        for (int i = 0; i < n; i++) begin
            check("write_addr", wq_a[i], exp_a[i]);
            check("write_data", wq_d[i], exp_d[i]);
        end
        wq_a.delete(); wq_d.delete(); wq_ce.delete();
        exp_a.delete(); exp_d.delete();
    endtask

    task automatic do_reset();
        reset = 1;
        repeat (3) @(negedge clk);
        reset = 0;
        wq_a.delete(); wq_d.delete(); wq_ce.delete();
        exp_a.delete(); exp_d.delete();
    endtask

    initial begin
        reset = 1; push_valid = 0; push_delay = 0; push_addr = 0; push_data = 0; flush = 0;
`ifdef SIDSEQ_SHADOW_EN
        shadow_raddr = 0;
`endif
        @(negedge clk);
        do_reset();

        check("rst_sid_we", sid_we, 0);
        check("rst_sid_addr", sid_addr, 0);
        check("rst_sid_data", sid_data, 0);
        check("rst_level", level, 0);
        check("rst_push_ready", push_ready, 1);
        check("rst_empty", empty, 1);
        check("rst_busy", busy, 0);

        // Single delay-0 write: lands one clk after the first tick following the pop.
        ce_period = 32;
        push(16'd0, 5'h18, 8'h0F);
        repeat (3) @(negedge clk);
        check("t1_busy_waiting", busy, 1);
        check("t1_level_popped", level, 0);
        ce0 = ce_count;
        ce_en = 1;
        for (int t = 0; t < 200 && wq_a.size() < 1; t++) @(negedge clk);
        check("t1_write_seen", wq_a.size(), 1);
        if (wq_ce.size() > 0) check("t1_tick_index", wq_ce[0], ce0 + 1);
        repeat (2) @(negedge clk);
        check("t1_we_low", sid_we, 0);
        check("t1_empty", empty, 1);
        check("t1_addr_hold", sid_addr, 5'h18);
        check("t1_data_hold", sid_data, 8'h0F);
        repeat (40) @(negedge clk);
        check_writes(10);

        // Back-to-back entries: delay 3 then delay 0.
        ce_en = 0;
        push(16'd3, 5'h00, 8'h11);
        push(16'd0, 5'h01, 8'h22);
        repeat (3) @(negedge clk);
        ce0 = ce_count;
        ce_en = 1;
        for (int t = 0; t < 400 && wq_a.size() < 2; t++) @(negedge clk);
        check("t2_write_seen", wq_a.size(), 2);
        if (wq_ce.size() > 1) begin
            check("t2_first_tick", wq_ce[0], ce0 + 4);
            check("t2_second_tick", wq_ce[1], ce0 + 5);
        end
        check_writes(10);

        // Fill: one entry sits in WAIT, sixteen more fill the FIFO.
        ce_en = 0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 17; i++) push(16'd0, 5'(i), 8'hA0 + 8'(i));
        check("t3_level_full", level, 16);
        check("t3_ready_low", push_ready, 0);
        push(16'd0, 5'h1F, 8'hEE);
        check("t3_overflow_dropped", level, 16);
        ce_period = 4;
        ce_en = 1;
        check_writes(300);
        repeat (2) @(negedge clk);
        check("t3_level_drained", level, 0);
        check("t3_empty", empty, 1);

        // Flush mid-wait: nothing is ever written, push in the flush cycle is dropped.
        ce_en = 0;
        repeat (2) @(negedge clk);
        push(16'd100, 5'h04, 8'h41);
        repeat (3) @(negedge clk);
        ce0 = ce_count;
        ce_en = 1;
        for (int t = 0; t < 200 && ce_count < ce0 + 10; t++) @(negedge clk);
        check("t4_ticks_reached", ce_count, ce0 + 10);
        flush = 1;
        push(16'd0, 5'h05, 8'h77);
        flush = 0;
        check("t4_level", level, 0);
        check("t4_busy", busy, 0);
        check("t4_empty", empty, 1);
        exp_a.delete(); exp_d.delete();
        repeat (500) @(negedge clk);
        check("t4_no_write", wq_a.size(), 0);

        // Steady push+pop at level 5, pointers wrap over 40 entries.
        ce_en = 0;
        for (int j = 0; j < 6; j++) push(16'd0, 5'(j), 8'h40 + 8'(j));
        repeat (2) @(negedge clk);
        check("t5_level_start", level, 5);
        ce_en = 1;
        for (int j = 6; j < 40; j++) begin
            for (int t = 0; t < 100 && busy == 1'b1; t++) @(negedge clk);
            push(16'd0, 5'(j), 8'h40 + 8'(j));
            check("t5_level_hold", level, 5);
        end
        check_writes(400);

`ifdef SIDSEQ_SHADOW_EN
        push(16'd0, 5'h03, 8'hFF);
        push(16'd0, 5'h1A, 8'h55);
        check_writes(200);
        shadow_raddr = 5'h03;
        @(negedge clk);
        check("sh_read_03", shadow_rdata, 8'hFF);
        shadow_raddr = 5'h1A;
        @(negedge clk);
        check("sh_read_1a", shadow_rdata, 8'h00);
        flush = 1;
        @(negedge clk);
        flush = 0;
        shadow_raddr = 5'h03;
        @(negedge clk);
        check("sh_after_flush", shadow_rdata, 8'hFF);
        do_reset();
        @(negedge clk);
        check("sh_after_reset", shadow_rdata, 8'h00);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
